// File: rtl/icache_ctrl_if.sv
// Bus bundle between the icache refill controller and its environment
// (IF stage / icache lookup side, memory read handshake, cache fill port).
// master: the refill controller. slave: the fetch/cache/memory side.
interface icache_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic                  hit;
  logic                  stall;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_data;
  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [31:0]           fill_data;
  logic                  fill_last;

  modport master (
    input  addr, hit, mem_ack, mem_data,
    output stall, mem_req, mem_addr, fill_we, fill_addr, fill_data, fill_last
  );

  modport slave (
    output addr, hit, mem_ack, mem_data,
    input  stall, mem_req, mem_addr, fill_we, fill_addr, fill_data, fill_last
  );
endinterface

// File: rtl/icache_ctrl.sv
// Instruction cache refill controller. On a miss it stalls fetch, reads the
// whole line word by word (in order from the line base) over a req/ack
// handshake and streams each word into the cache fill port one cycle after
// its ack.
// Optional miss counter: define ICACHE_CTRL_STATS_EN to build it; otherwise
// miss_count is tied to zero.
module icache_ctrl #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  icache_ctrl_if.master bus,
  output logic [31:0]   miss_count
);

  localparam int unsigned CW = $clog2(LINE_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0]         LAST_WORD = CW'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(LINE_WORDS * 4 - 1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  fill_we_q;
  logic [ADDR_WIDTH-1:0] fill_addr_q;
  logic [31:0]           fill_data_q;
  logic                  fill_last_q;

  logic                  miss_start;
  logic                  ack_fetch;
  logic                  word_last;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign miss_start = (state_q == S_IDLE) && !bus.hit;
  assign ack_fetch  = (state_q == S_FETCH) && bus.mem_ack;
  assign word_last  = (cnt_q == LAST_WORD);
  // base_q has its offset bits cleared, so OR-ing the word offset is base+4*cnt
  assign word_addr  = base_q | ADDR_WIDTH'({cnt_q, 2'b00});

  // Next-state logic: latch line on miss, walk words on each ack, one DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.hit) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          base_d  = bus.addr & ~OFF_MASK;
        end
      end
      S_FETCH: begin
        if (bus.mem_ack) begin
          if (word_last) state_d = S_DONE;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // Fill port: registered copy of each accepted memory word
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_we_q   <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      fill_last_q <= 1'b0;
    end else begin
      fill_we_q   <= ack_fetch;
      fill_last_q <= ack_fetch && word_last;
      if (ack_fetch) begin
        fill_addr_q <= word_addr;
        fill_data_q <= bus.mem_data;
      end
    end
  end

  assign bus.stall     = !reset && ((state_q != S_IDLE) || !bus.hit);
  assign bus.mem_req   = (state_q == S_FETCH);
  assign bus.mem_addr  = word_addr;
  assign bus.fill_we   = fill_we_q;
  assign bus.fill_addr = fill_addr_q;
  assign bus.fill_data = fill_data_q;
  assign bus.fill_last = fill_last_q;

`ifdef ICACHE_CTRL_STATS_EN
  logic [31:0] miss_q;

  // Miss counter: one count per IDLE->FETCH transition, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)           miss_q <= '0;
    else if (miss_start) miss_q <= miss_q + 32'd1;
  end

  assign miss_count = miss_q;
`else
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized bench for icache_ctrl. A behavioural model tracks which lines
// are resident, the outstanding refill (words fetched, waits inserted) and a
// scoreboard of expected fill writes, and checks every cycle.
module tb_icache_ctrl;

  localparam int unsigned LW     = 4;
  localparam int unsigned AW     = 32;
  localparam int unsigned LBYTES = LW * 4;
  localparam int unsigned NCYC   = 4000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } fill_t;

  logic        clk;
  logic        reset;
  logic [31:0] miss_count;

  icache_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  icache_ctrl #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  bit          valid [int unsigned];
  logic [31:0] pool [8];
  fill_t       fillq [$];
  bit          busy;
  bit          done_phase;
  int unsigned req_idx;
  int unsigned wait_left;
  int unsigned tot_wait;
  int unsigned stall_len;
  logic [31:0] base;
  logic [31:0] miss_model;
  logic [31:0] exp_miss;
  bit          rst_now;
  fill_t       f;
  logic [31:0] d;

  function automatic bit resident(input logic [31:0] a);
    int unsigned k = a / LBYTES;
    return valid.exists(k) ? valid[k] : 1'b0;
  endfunction

  function automatic int unsigned pick_wait();
    return ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
  endfunction

  initial begin
    reset        = 1'b1;
    bus.addr     = '0;
    bus.hit      = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    for (int i = 0; i < 8; i++) pool[i] = $urandom & ~(LBYTES - 1);
    busy = 0; done_phase = 0; miss_model = '0;

    // Reset held two cycles with a miss presented: everything quiet
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_stall",     32'(bus.stall),     32'd0);
    check_eq("rst_mem_req",   32'(bus.mem_req),   32'd0);
    check_eq("rst_mem_addr",  bus.mem_addr,       32'd0);
    check_eq("rst_fill_we",   32'(bus.fill_we),   32'd0);
    check_eq("rst_fill_addr", bus.fill_addr,      32'd0);
    check_eq("rst_fill_data", bus.fill_data,      32'd0);
    check_eq("rst_fill_last", 32'(bus.fill_last), 32'd0);
    check_eq("rst_miss_cnt",  miss_count,         32'd0);

    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (!busy && (cyc % 60) == 0) valid.delete();
      rst_now      = busy && ($urandom_range(0, 59) == 0);
      reset        = rst_now;
      // addr wanders every cycle; while refilling it must be ignored
      bus.addr     = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, LBYTES - 1));
      bus.hit      = resident(bus.addr);
      bus.mem_ack  = 1'b0;
      bus.mem_data = $urandom;
      #1;

`ifdef ICACHE_CTRL_STATS_EN
      exp_miss = miss_model;
`else
      exp_miss = '0;
`endif
      check_eq("miss_count", miss_count, exp_miss);

      // Fill port reflects the ack of the previous cycle only
      if (fillq.size() != 0) begin
        f = fillq.pop_front();
        check_eq("fill_we",   32'(bus.fill_we),   32'd1);
        check_eq("fill_addr", bus.fill_addr,      f.addr);
        check_eq("fill_data", bus.fill_data,      f.data);
        check_eq("fill_last", 32'(bus.fill_last), 32'(f.last));
        if (f.last) valid[f.addr / LBYTES] = 1'b1;
      end else begin
        check_eq("fill_we_idle", 32'(bus.fill_we), 32'd0);
      end

      if (rst_now) begin
        check_eq("stall_in_reset", 32'(bus.stall), 32'd0);
        bus.mem_ack = 1'($urandom_range(0, 1));
        busy = 0; done_phase = 0; miss_model = '0;
        fillq.delete();
      end else if (!busy) begin
        check_eq("idle_mem_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ack = ($urandom_range(0, 3) == 0);  // stray ack, must be ignored
        if (bus.hit) begin
          check_eq("hit_stall", 32'(bus.stall), 32'd0);
        end else begin
          check_eq("miss_stall", 32'(bus.stall), 32'd1);
          busy       = 1;
          done_phase = 0;
          req_idx    = 0;
          base       = bus.addr & ~(LBYTES - 1);
          wait_left  = pick_wait();
          tot_wait   = wait_left;
          stall_len  = 1;
          miss_model = miss_model + 32'd1;
        end
      end else begin
        check_eq("busy_stall", 32'(bus.stall), 32'd1);
        stall_len++;
        if (done_phase) begin
          check_eq("done_mem_req", 32'(bus.mem_req), 32'd0);
          check_eq("stall_cycles", stall_len, LW + 2 + tot_wait);
          bus.mem_ack = ($urandom_range(0, 3) == 0);
          busy = 0;
        end else begin
          check_eq("mem_req",  32'(bus.mem_req), 32'd1);
          check_eq("mem_addr", bus.mem_addr, base + 4 * req_idx);
          if (wait_left == 0) begin
            d = $urandom;
            bus.mem_ack  = 1'b1;
            bus.mem_data = d;
            fillq.push_back('{addr: base + 4 * req_idx, data: d, last: (req_idx == LW - 1)});
            req_idx++;
            if (req_idx == LW) begin
              done_phase = 1;
            end else begin
              wait_left = pick_wait();
              tot_wait += wait_left;
            end
          end else begin
            wait_left--;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
